// File: rtl/sha256_job_sched.sv
// sha256_job_sched
//
// Shares one SHA-256 core among NUM_REQ requesters. It picks one requester by
// round-robin, hands that requester's addresses to the core, waits for the core
// to finish, then sends a one-cycle ack back to the same requester.
//
// Parameters
//   NUM_REQ         number of requesters (2..8)
//   TIMEOUT_CYCLES  watchdog limit per job, in clk cycles (at least 2)
//
// Ports
//   clk                in   single clock, rising edge
//   reset              in   asynchronous reset, active high
//   req[NUM_REQ]       in   job request level per requester, held until its ack
//   req_msg_addr       in   16-bit message address per requester, slice r = [16r+15:16r]
//   req_out_addr       in   16-bit hash output address per requester, same slicing
//   ack[NUM_REQ]       out  one-hot, one-cycle job-complete pulse
//   err                out  high in the ack cycle when the job ended by watchdog timeout
//   busy               out  high whenever the scheduler is not idle
//   core_start         out  one-cycle start pulse to the core
//   core_message_addr  out  message address for the current job
//   core_output_addr   out  output address for the current job
//   core_done          in   core idle level (high while the core is idle)
//
// Build option
//   SHA_SCHED_TIMEOUT_EN  when defined, enables the per-job watchdog. When it is
//                         not defined there is no counter, err stays 0, and a job
//                         waits for the core with no time limit.
//
// state     | meaning
// IDLE      | waiting for an idle core and a pending request
// ISSUE     | core_start pulse with the latched addresses
// WAIT_BUSY | waiting for the core to leave its idle state
// WAIT_DONE | waiting for the core to return to its idle state
// ACK       | ack pulse to the winner; err if the watchdog fired

module sha256_job_sched #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  req_msg_addr,
    input  logic [16*NUM_REQ-1:0]  req_out_addr,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   err,
    output logic                   busy,
    output logic                   core_start,
    output logic [15:0]            core_message_addr,
    output logic [15:0]            core_output_addr,
    input  logic                   core_done
);

    localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("sha256_job_sched: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("sha256_job_sched: TIMEOUT_CYCLES must be at least 2");
    end

    logic [2:0]       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] ptr_nxt;
    logic             pick_vld;
    logic             timeout;
    logic [15:0]      msg_arr [NUM_REQ];
    logic [15:0]      out_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
        assign msg_arr[g] = req_msg_addr[16*g +: 16];
        assign out_arr[g] = req_out_addr[16*g +: 16];
    end

    // Round-robin search starting at ptr. The loop runs from the farthest
    // offset down to offset 0, so the last hit, the one that is kept, is the
    // nearest requester at or after ptr.
    always_comb begin
        logic [IDX_W-1:0] idx;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    // After a grant the pointer moves one past the winner, so the winner
    // ranks last in the next search.
    assign ptr_nxt = (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= S_IDLE;
            ptr               <= '0;
            winner            <= '0;
            core_message_addr <= '0;
            core_output_addr  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (core_done && pick_vld) begin
                        winner            <= pick;
                        ptr               <= ptr_nxt;
                        core_message_addr <= msg_arr[pick];
                        core_output_addr  <= out_arr[pick];
                        state             <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT_BUSY;
                S_WAIT_BUSY: begin
                    if (timeout)
                        state <= S_ACK;
                    else if (!core_done)
                        state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (core_done || timeout)
                        state <= S_ACK;
                end
                S_ACK:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SHA_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             err_q;
    logic             waiting;

    assign waiting = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);

    // wd_cnt counts finished wait cycles. Together with the ISSUE cycle the
    // job has used TIMEOUT_CYCLES cycles when the ACK state is entered.
    assign timeout = waiting && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else if (state == S_ISSUE) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else if (waiting) begin
            wd_cnt <= wd_cnt + 1'b1;
            // When the core finishes in the same cycle as the timeout, the
            // job counts as a normal completion.
            if (timeout && !(state == S_WAIT_DONE && core_done))
                err_q <= 1'b1;
        end
    end

    assign err = err_q && (state == S_ACK);
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // These outputs are decoded from state, so an asynchronous reset clears
    // them at once.
    assign core_start = (state == S_ISSUE);
    assign busy       = (state != S_IDLE);
    assign ack        = (state == S_ACK) ? (NUM_REQ'(1) << winner) : '0;

endmodule

// File: tb/tb_sha256_job_sched.sv
module tb_sha256_job_sched;

    localparam int N  = 4;
    localparam int TO = 16;
`ifdef SHA_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req;
    logic [16*N-1:0]   msg_a;
    logic [16*N-1:0]   out_a;
    logic [N-1:0]      ack;
    logic              err;
    logic              busy;
    logic              core_start;
    logic [15:0]       core_message_addr;
    logic [15:0]       core_output_addr;
    logic              core_done;
    logic              done_m;
    logic              core_hold;

    assign core_done = done_m & ~core_hold;

    always #5 clk = ~clk;

    sha256_job_sched #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk               (clk),
        .reset             (reset),
        .req               (req),
        .req_msg_addr      (msg_a),
        .req_out_addr      (out_a),
        .ack               (ack),
        .err               (err),
        .busy              (busy),
        .core_start        (core_start),
        .core_message_addr (core_message_addr),
        .core_output_addr  (core_output_addr),
        .core_done         (core_done)
    );

    typedef struct packed {
        logic [15:0] msg;
        logic [15:0] out;
    } start_t;

    typedef struct packed {
        logic [N-1:0] a;
        logic         e;
    } ack_t;

    start_t exp_start[$];
    ack_t   exp_ack[$];
    start_t cur;
    logic   mon_active;
    int     n_tests = 0;
    int     n_fail  = 0;
    int     lat;
    bit     no_drop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event did not match the expected sequence", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ack(input string name, input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(|ack) && cyc < budget);
        if (!(|ack)) fail_now({name, "_ack_timeout"});
    endtask

    task automatic wait_start(input string name, input int budget);
        int c;
        c = 0;
        while (!core_start && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (!core_start) fail_now({name, "_start_timeout"});
    endtask

    task automatic wait_core_idle(input int budget);
        int c;
        c = 0;
        while (!done_m && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (!done_m) fail_now("core_idle_timeout");
    endtask

    task automatic set_addr(input int r, input logic [15:0] m, input logic [15:0] o);
        msg_a[16*r +: 16] = m;
        out_a[16*r +: 16] = o;
    endtask

    // Core model: done drops 2 cycles after a start and rises lat cycles later.
    initial begin
        done_m = 1'b1;
        forever begin
            @(negedge clk);
            if (core_start && !no_drop) begin
                repeat (2) @(negedge clk);
                done_m = 1'b0;
                repeat (lat) @(negedge clk);
                done_m = 1'b1;
            end
        end
    end

    // Monitor: pops expected starts/acks and checks address hold during a job.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (core_start) begin
                    check("start_while_active", {31'd0, mon_active}, 32'd0);
                    if (exp_start.size() == 0) begin
                        fail_now("unexpected_start");
                    end else begin
                        cur = exp_start.pop_front();
                        check("start_msg", {16'd0, core_message_addr}, {16'd0, cur.msg});
                        check("start_out", {16'd0, core_output_addr}, {16'd0, cur.out});
                    end
                    mon_active = 1'b1;
                end else if (mon_active && busy) begin
                    check("msg_hold", {16'd0, core_message_addr}, {16'd0, cur.msg});
                    check("out_hold", {16'd0, core_output_addr}, {16'd0, cur.out});
                end
                if (|ack) begin
                    if (exp_ack.size() == 0) begin
                        fail_now("unexpected_ack");
                    end else begin
                        ack_t e;
                        e = exp_ack.pop_front();
                        check("ack_vec", {28'd0, ack}, {28'd0, e.a});
                        check("ack_err", {31'd0, err}, {31'd0, e.e});
                    end
                    mon_active = 1'b0;
                end
            end
        end
    end

    initial begin
        int cyc;
        reset      = 1'b1;
        req        = '0;
        msg_a      = '0;
        out_a      = '0;
        core_hold  = 1'b0;
        lat        = 5;
        no_drop    = 1'b0;
        mon_active = 1'b0;

        tick(3);
        check("rst_ack",   {28'd0, ack}, 32'd0);
        check("rst_err",   {31'd0, err}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_start", {31'd0, core_start}, 32'd0);
        check("rst_msg",   {16'd0, core_message_addr}, 32'd0);
        check("rst_out",   {16'd0, core_output_addr}, 32'd0);
        reset = 1'b0;
        tick(2);

        // Single request with a long core job.
        lat = 150;
        set_addr(0, 16'h0000, 16'h0100);
        exp_start.push_back('{msg: 16'h0000, out: 16'h0100});
        exp_ack.push_back('{a: 4'b0001, e: TO_EN});
        req = 4'b0001;
        wait_ack("single", 300, cyc);
        req = '0;
        tick(1);
        check("ack_one_cycle", {28'd0, ack}, 32'd0);
        wait_core_idle(300);
        tick(2);

        // Contention from ptr=0 after a reset.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        lat = 5;
        for (int r = 0; r < N; r++) set_addr(r, 16'h1000 + 16'(r), 16'h2000 + 16'(r));
        for (int k = 0; k < 5; k++) begin
            exp_start.push_back('{msg: 16'h1000 + 16'(k % N), out: 16'h2000 + 16'(k % N)});
            exp_ack.push_back('{a: 4'b0001 << (k % N), e: 1'b0});
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) wait_ack("contention", 50, cyc);
        req = '0;
        tick(3);

        // Core busy at request time; requester 1 withdraws before any grant.
        core_hold = 1'b1;
        req = 4'b0010;
        tick(3);
        req = '0;
        set_addr(2, 16'h2222, 16'h3333);
        req = 4'b0100;
        tick(10);
        lat = 8;
        exp_start.push_back('{msg: 16'h2222, out: 16'h3333});
        exp_ack.push_back('{a: 4'b0100, e: 1'b0});
        core_hold = 1'b0;
        @(negedge clk);
        check("grant_after_done", {31'd0, core_start}, 32'd1);

        // Address change and req drop after the grant must not disturb the job.
        set_addr(2, 16'hFFFF, 16'hFFFF);
        req = '0;
        wait_ack("addr_change", 60, cyc);
        tick(3);

`ifdef SHA_SCHED_TIMEOUT_EN
        // Core never leaves idle: the watchdog ends the job.
        no_drop = 1'b1;
        set_addr(3, 16'h4444, 16'h5555);
        exp_start.push_back('{msg: 16'h4444, out: 16'h5555});
        exp_ack.push_back('{a: 4'b1000, e: 1'b1});
        req = 4'b1000;
        wait_start("timeout", 20);
        wait_ack("timeout", 40, cyc);
        n_tests++;
        if (cyc > TO || cyc < 2) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d cycles expected at most %0d", cyc, TO);
        end
        req = '0;
        no_drop = 1'b0;
        tick(2);
        check("timeout_idle", {31'd0, busy}, 32'd0);
        tick(2);
`endif

        // Reset during WAIT_DONE aborts the job silently and clears ptr.
        lat = 20;
        set_addr(1, 16'h6666, 16'h7777);
        exp_start.push_back('{msg: 16'h6666, out: 16'h7777});
        req = 4'b0010;
        wait_start("reset_job", 20);
        tick(5);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_start", {31'd0, core_start}, 32'd0);
        check("mid_rst_busy",  {31'd0, busy}, 32'd0);
        check("mid_rst_ack",   {28'd0, ack}, 32'd0);
        check("mid_rst_err",   {31'd0, err}, 32'd0);
        check("mid_rst_msg",   {16'd0, core_message_addr}, 32'd0);
        check("mid_rst_out",   {16'd0, core_output_addr}, 32'd0);
        mon_active = 1'b0;
        tick(2);
        req = '0;
        reset = 1'b0;
        tick(40);
        wait_core_idle(100);
        tick(1);

        // With ptr back at 0 requester 1 wins over 3 (ptr=2 would pick 3).
        lat = 5;
        set_addr(1, 16'h8888, 16'h9999);
        set_addr(3, 16'hAAAA, 16'hBBBB);
        exp_start.push_back('{msg: 16'h8888, out: 16'h9999});
        exp_ack.push_back('{a: 4'b0010, e: 1'b0});
        req = 4'b1010;
        wait_ack("ptr_after_reset", 50, cyc);
        req = '0;
        tick(3);

        check("start_queue_empty", exp_start.size(), 32'd0);
        check("ack_queue_empty", exp_ack.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
